// File: rtl/load_store_unit.sv
// -----------------------------------------------------------------------------
// load_store_unit
//
// Data-memory access stage that sits after the ALU. The ALU result is the
// effective byte address of a load or store; the block runs one
// request/acknowledge transaction on the data bus, aligns and extends load
// data, and stalls the core until the access has finished. Misaligned
// addresses and illegal funct3 codes complete as faults without touching the
// bus. An access with no acknowledge for TIMEOUT cycles is aborted as a bus
// error.
//
// Ports
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   mem_read          current instruction is a load
//   mem_write         current instruction is a store (wins over mem_read)
//   funct3            size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
//   alu_result        effective byte address
//   write_data        store data (rs2)
//   stall             core holds PC / register write while high
//   done              one-cycle completion pulse
//   read_data         extended load result, valid while done
//   misaligned        misalignment / illegal-code fault, valid while done
//   bus_err           timeout fault, valid while done
//   bus_req/we/addr/be/wdata  registered bus request
//   bus_ack           slave accepts; bus_rdata valid in the same cycle
//   bus_rdata         read data from slave
// -----------------------------------------------------------------------------
module load_store_unit #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [2:0]  funct3,
  input  logic [31:0] alu_result,
  input  logic [31:0] write_data,
  output logic        stall,
  output logic        done,
  output logic [31:0] read_data,
  output logic        misaligned,
  output logic        bus_err,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam logic [7:0] LAST_WAIT = 8'(TIMEOUT - 1);

  state_t      state_reg;
  logic [7:0]  wait_cnt_reg;
  logic [2:0]  f3_reg;
  logic [1:0]  offset_reg;
  logic        fault_reg;
  logic        err_reg;

  logic        access_req;
  logic        illegal;
  logic        unaligned;
  logic [3:0]  be_next;
  logic [31:0] wdata_next;
  logic [31:0] shifted;
  logic [31:0] load_ext;

  // ---------------------------------------------------------------------------
  // Request decode (only meaningful in IDLE)
  // ---------------------------------------------------------------------------
  assign access_req = mem_read | mem_write;

  // 011, 11x are never legal; the unsigned variants (1xx) only exist for loads.
  assign illegal = (funct3 == 3'b011) || (funct3[2:1] == 2'b11) ||
                   (mem_write && funct3[2]);

  // funct3[1:0] gives the size for both signed and unsigned codes.
  assign unaligned = ((funct3[1:0] == 2'b01) && alu_result[0]) ||
                     ((funct3[1:0] == 2'b10) && (alu_result[1:0] != 2'b00));

  always_comb begin
    be_next = 4'b1111;
    case (funct3[1:0])
      2'b00:   be_next = 4'b0001 << alu_result[1:0];
      2'b01:   be_next = 4'b0011 << alu_result[1:0];
      default: be_next = 4'b1111;
    endcase
  end

  // Store data is replicated across lanes so the enabled lanes always carry
  // the right bytes regardless of the address offset.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_wdata_lane
      assign wdata_next[8*gi +: 8] =
          (funct3[1:0] == 2'b00) ? write_data[7:0] :
          (funct3[1:0] == 2'b01) ? write_data[8*(gi % 2) +: 8] :
                                   write_data[8*gi +: 8];
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Load alignment and extension
  // ---------------------------------------------------------------------------
  assign shifted = bus_rdata >> {offset_reg, 3'b000};

  always_comb begin
    load_ext = shifted;
    case (f3_reg)
      3'b000:  load_ext = {{24{shifted[7]}},  shifted[7:0]};
      3'b001:  load_ext = {{16{shifted[15]}}, shifted[15:0]};
      3'b100:  load_ext = {24'd0, shifted[7:0]};
      3'b101:  load_ext = {16'd0, shifted[15:0]};
      default: load_ext = shifted;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Control FSM with registered bus request
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      wait_cnt_reg <= 8'd0;
      f3_reg       <= 3'd0;
      offset_reg   <= 2'd0;
      fault_reg    <= 1'b0;
      err_reg      <= 1'b0;
      read_data    <= 32'd0;
      bus_req      <= 1'b0;
      bus_we       <= 1'b0;
      bus_addr     <= 32'd0;
      bus_be       <= 4'd0;
      bus_wdata    <= 32'd0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (access_req) begin
            f3_reg     <= funct3;
            offset_reg <= alu_result[1:0];
            err_reg    <= 1'b0;
            if (illegal || unaligned) begin
              state_reg <= DONE;
              fault_reg <= 1'b1;
              read_data <= 32'd0;
            end else begin
              state_reg    <= ACCESS;
              fault_reg    <= 1'b0;
              wait_cnt_reg <= 8'd0;
              bus_req      <= 1'b1;
              bus_we       <= mem_write;
              bus_addr     <= {alu_result[31:2], 2'b00};
              bus_be       <= be_next;
              bus_wdata    <= wdata_next;
            end
          end
        end

        ACCESS: begin
          // An acknowledge in the final wait cycle still completes normally.
          if (bus_ack) begin
            state_reg <= DONE;
            bus_req   <= 1'b0;
            read_data <= bus_we ? 32'd0 : load_ext;
          end else if (wait_cnt_reg == LAST_WAIT) begin
            state_reg <= DONE;
            bus_req   <= 1'b0;
            err_reg   <= 1'b1;
            read_data <= 32'd0;
          end else begin
            wait_cnt_reg <= wait_cnt_reg + 8'd1;
          end
        end

        DONE:    state_reg <= IDLE;
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign done       = (state_reg == DONE);
  assign misaligned = done && fault_reg;
  assign bus_err    = done && err_reg;
  assign stall      = (state_reg == ACCESS) || ((state_reg == IDLE) && access_req);

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mem_read, mem_write;
  logic [2:0]  funct3;
  logic [31:0] alu_result, write_data;
  logic        stall, done, misaligned, bus_err;
  logic [31:0] read_data;
  logic        bus_req, bus_we;
  logic [31:0] bus_addr, bus_wdata;
  logic [3:0]  bus_be;
  logic        bus_ack;
  logic [31:0] bus_rdata;

  int errors = 0;
  int checks = 0;

  // Observations from one access
  int          n_stall, n_req;
  logic [31:0] o_addr, o_wdata, o_rdata;
  logic [3:0]  o_be;
  logic        o_we, o_done, o_mis, o_err, o_tmo;

  load_store_unit #(.TIMEOUT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .mem_read(mem_read), .mem_write(mem_write), .funct3(funct3),
    .alu_result(alu_result), .write_data(write_data),
    .stall(stall), .done(done), .read_data(read_data),
    .misaligned(misaligned), .bus_err(bus_err),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_be(bus_be), .bus_wdata(bus_wdata),
    .bus_ack(bus_ack), .bus_rdata(bus_rdata)
  );

  always #5 clk = ~clk;

  // Runs one access from IDLE; ack_at = ACCESS cycle that gets bus_ack (0 = none).
  // Returns at posedge+1 with the DUT back in IDLE.
  task automatic run_access(input logic wr, input logic rd, input logic [2:0] f3,
                            input logic [31:0] addr, input logic [31:0] wd,
                            input logic [31:0] rdata, input int ack_at);
    mem_read = rd; mem_write = wr; funct3 = f3; alu_result = addr;
    write_data = wd; bus_ack = 1'b0; bus_rdata = 32'd0;
    n_stall = 0; n_req = 0; o_tmo = 1'b1;
    o_addr = '0; o_wdata = '0; o_be = '0; o_we = 1'b0;
    o_done = 1'b0; o_mis = 1'b0; o_err = 1'b0; o_rdata = '0;
    for (int c = 0; c < 40; c++) begin
      #1;
      if (done) begin
        o_done = done; o_mis = misaligned; o_err = bus_err; o_rdata = read_data;
        o_tmo = 1'b0;
        break;
      end
      if (stall) n_stall++;
      if (bus_req) begin
        n_req++;
        if (n_req == 1) begin
          o_addr = bus_addr; o_wdata = bus_wdata; o_be = bus_be; o_we = bus_we;
        end
        bus_ack   = (n_req == ack_at);
        bus_rdata = rdata;
      end else begin
        bus_ack = 1'b0;
      end
      @(posedge clk); #1;
      mem_read = 1'b0; mem_write = 1'b0;
    end
    mem_read = 1'b0; mem_write = 1'b0; bus_ack = 1'b0;
    if (o_tmo) begin
      errors++;
      $display("FAIL access_timeout: done never seen, got done=0 required done=1");
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; mem_read = 0; mem_write = 0; funct3 = 0; alu_result = 0;
    write_data = 0; bus_ack = 0; bus_rdata = 0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({bus_req, bus_we, bus_addr, bus_be, bus_wdata, read_data, done, misaligned, bus_err, stall} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: req=%b we=%b addr=%h be=%b wdata=%h rd=%h done=%b mis=%b err=%b stall=%b, required all 0",
               bus_req, bus_we, bus_addr, bus_be, bus_wdata, read_data, done, misaligned, bus_err, stall);
    end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_store_word();
    run_access(1'b1, 1'b0, 3'b010, 32'h100, 32'hDEADBEEF, 32'h0, 1);
    checks++;
    if ({o_addr, o_be, o_wdata, o_we} !== {32'h100, 4'b1111, 32'hDEADBEEF, 1'b1}) begin
      errors++;
      $display("FAIL sw_bus: addr=%h be=%b wdata=%h we=%b required 00000100 1111 deadbeef 1", o_addr, o_be, o_wdata, o_we);
    end
    checks++;
    if (n_stall !== 2) begin errors++; $display("FAIL sw_stall: got %0d cycles required 2", n_stall); end
    checks++;
    if ({o_done, o_rdata, o_mis, o_err} !== {1'b1, 32'h0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL sw_done: done=%b rd=%h mis=%b err=%b required 1 00000000 0 0", o_done, o_rdata, o_mis, o_err);
    end
    checks++;
    if (done !== 1'b0) begin errors++; $display("FAIL done_pulse: done=%b one cycle after DONE, required 0", done); end
  endtask

  task automatic test_load_byte();
    run_access(1'b0, 1'b1, 3'b000, 32'h103, 32'h0, 32'h80FF1234, 1);
    checks++;
    if ({o_be, o_we, o_addr} !== {4'b1000, 1'b0, 32'h100}) begin
      errors++;
      $display("FAIL lb_bus: be=%b we=%b addr=%h required 1000 0 00000100", o_be, o_we, o_addr);
    end
    checks++;
    if (o_rdata !== 32'hFFFFFF80) begin errors++; $display("FAIL lb_data: got %h required ffffff80", o_rdata); end
    run_access(1'b0, 1'b1, 3'b100, 32'h103, 32'h0, 32'h80FF1234, 1);
    checks++;
    if (o_rdata !== 32'h00000080) begin errors++; $display("FAIL lbu_data: got %h required 00000080", o_rdata); end
  endtask

  task automatic test_halfword();
    run_access(1'b1, 1'b0, 3'b001, 32'h102, 32'h0000ABCD, 32'h0, 1);
    checks++;
    if ({o_be, o_wdata} !== {4'b1100, 32'hABCDABCD}) begin
      errors++;
      $display("FAIL sh_bus: be=%b wdata=%h required 1100 abcdabcd", o_be, o_wdata);
    end
    run_access(1'b0, 1'b1, 3'b001, 32'h102, 32'h0, 32'hABCD0000, 1);
    checks++;
    if (o_rdata !== 32'hFFFFABCD) begin errors++; $display("FAIL lh_data: got %h required ffffabcd", o_rdata); end
    checks++;
    if (read_data !== 32'hFFFFABCD) begin errors++; $display("FAIL rd_hold: got %h in IDLE required ffffabcd", read_data); end
  endtask

  task automatic test_both_is_store();
    run_access(1'b1, 1'b1, 3'b000, 32'h101, 32'h000000AA, 32'h55555555, 1);
    checks++;
    if ({o_we, o_be, o_wdata, o_rdata} !== {1'b1, 4'b0010, 32'hAAAAAAAA, 32'h0}) begin
      errors++;
      $display("FAIL both_store: we=%b be=%b wdata=%h rd=%h required 1 0010 aaaaaaaa 00000000", o_we, o_be, o_wdata, o_rdata);
    end
  endtask

  task automatic test_faults();
    logic        wr_v [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic [2:0]  f3_v [4] = '{3'b010, 3'b001, 3'b011, 3'b100};
    logic [31:0] ad_v [4] = '{32'h101, 32'h101, 32'h100, 32'h100};
    for (int i = 0; i < 4; i++) begin
      run_access(wr_v[i], ~wr_v[i], f3_v[i], ad_v[i], 32'h12345678, 32'hFFFFFFFF, 1);
      checks++;
      if ({o_done, o_mis, o_err, o_rdata} !== {1'b1, 1'b1, 1'b0, 32'h0} || n_stall !== 1 || n_req !== 0) begin
        errors++;
        $display("FAIL fault_%0d: done=%b mis=%b err=%b rd=%h stall=%0d req=%0d required 1 1 0 00000000 1 0",
                 i, o_done, o_mis, o_err, o_rdata, n_stall, n_req);
      end
    end
  endtask

  task automatic test_timeout();
    run_access(1'b0, 1'b1, 3'b010, 32'h104, 32'h0, 32'h12345678, 0);
    checks++;
    if (n_req !== 4 || n_stall !== 5) begin
      errors++;
      $display("FAIL tmo_cycles: req=%0d stall=%0d required 4 5", n_req, n_stall);
    end
    checks++;
    if ({o_done, o_err, o_mis, o_rdata} !== {1'b1, 1'b1, 1'b0, 32'h0}) begin
      errors++;
      $display("FAIL tmo_done: done=%b err=%b mis=%b rd=%h required 1 1 0 00000000", o_done, o_err, o_mis, o_rdata);
    end
    run_access(1'b0, 1'b1, 3'b010, 32'h104, 32'h0, 32'h12345678, 4);
    checks++;
    if ({o_err, o_rdata} !== {1'b0, 32'h12345678} || n_req !== 4) begin
      errors++;
      $display("FAIL late_ack: err=%b rd=%h req=%0d required 0 12345678 4", o_err, o_rdata, n_req);
    end
  endtask

  task automatic test_async_reset();
    mem_read = 1'b1; funct3 = 3'b010; alu_result = 32'h200; bus_ack = 1'b0;
    @(posedge clk); #1;
    mem_read = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (bus_req !== 1'b1) begin errors++; $display("FAIL rst_pre: bus_req=%b required 1", bus_req); end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bus_req, bus_we, bus_addr, bus_be, bus_wdata, read_data, done, misaligned, bus_err, stall} !== '0) begin
      errors++;
      $display("FAIL rst_async: req=%b addr=%h be=%b rd=%h done=%b stall=%b required all 0",
               bus_req, bus_addr, bus_be, read_data, done, stall);
    end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    run_access(1'b0, 1'b1, 3'b010, 32'h200, 32'h0, 32'hCAFEF00D, 1);
    checks++;
    if ({o_done, o_err, o_mis, o_rdata} !== {1'b1, 1'b0, 1'b0, 32'hCAFEF00D} || n_stall !== 2) begin
      errors++;
      $display("FAIL rst_after: done=%b err=%b mis=%b rd=%h stall=%0d required 1 0 0 cafef00d 2",
               o_done, o_err, o_mis, o_rdata, n_stall);
    end
  endtask

  initial begin
    test_reset();
    test_store_word();
    test_load_byte();
    test_halfword();
    test_both_is_store();
    test_faults();
    test_timeout();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
